// File: rtl/booth_seq_multiplier.sv
// Sequential radix-4 Booth signed multiplier: WIDTH x WIDTH -> {hi,lo}, two multiplier bits per clock.
module booth_seq_multiplier #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             start,
   input  logic [WIDTH-1:0] multiplicand,
   input  logic [WIDTH-1:0] multiplier,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   // Accumulator carries two guard bits so +/-2M never overflows.
   localparam int unsigned AW    = WIDTH + 2;
   localparam int unsigned STEPS = WIDTH / 2;
   localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] m_reg;
   logic [WIDTH-1:0] q_reg;
   logic             q_m1;
   logic [AW-1:0]    a_reg;

   logic [AW-1:0]    m_ext;
   logic [AW-1:0]    m_dbl;
   logic [AW-1:0]    addend;
   logic [AW-1:0]    sum;
   logic [AW-1:0]    a_next;
   logic [WIDTH-1:0] q_next;

   // State register.
   always_ff @(posedge clock) begin
      if (clear) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state logic: IDLE -> RUN on start, RUN for STEPS cycles, DONE for one cycle.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (count == LAST_STEP) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // One Booth step: recode {Q[1:0],q_-1}, add the partial product, arithmetic shift right by 2.
   always_comb begin
      m_ext  = {{2{m_reg[WIDTH-1]}}, m_reg};
      m_dbl  = {m_ext[AW-2:0], 1'b0};
      addend = '0;
      case ({q_reg[1:0], q_m1})
         3'b001, 3'b010: addend = m_ext;
         3'b011:         addend = m_dbl;
         3'b100:         addend = -m_dbl;
         3'b101, 3'b110: addend = -m_ext;
         default:        addend = '0;
      endcase
      sum    = a_reg + addend;
      a_next = {{2{sum[AW-1]}}, sum[AW-1:2]};
      q_next = {sum[1:0], q_reg[WIDTH-1:2]};
   end

   // Datapath: operand capture on accept, one step per RUN cycle, product capture on the last step.
   always_ff @(posedge clock) begin
      if (clear) begin
         count <= '0;
         m_reg <= '0;
         q_reg <= '0;
         q_m1  <= 1'b0;
         a_reg <= '0;
         hi    <= '0;
         lo    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  m_reg <= multiplicand;
                  q_reg <= multiplier;
                  a_reg <= '0;
                  q_m1  <= 1'b0;
                  count <= '0;
               end
            end
            RUN: begin
               a_reg <= a_next;
               q_reg <= q_next;
               q_m1  <= q_reg[1];
               if (count == LAST_STEP) begin
                  count <= '0;
                  hi    <= a_next[WIDTH-1:0];
                  lo    <= q_next;
               end else begin
                  count <= count + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Status decoded straight from the state register.
   assign busy = (state != IDLE);
   assign done = (state == DONE);

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Bench for booth_seq_multiplier: directed corners, interference, abort, then random back-to-back ops.
module tb_booth_seq_multiplier;

   localparam int unsigned W = 32;

   logic         clock = 1'b0;
   logic         clear;
   logic         start;
   logic [W-1:0] multiplicand;
   logic [W-1:0] multiplier;
   logic         busy;
   logic         done;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   int n_cmp = 0;
   int n_bad = 0;
   logic [2*W-1:0] exp_q[$];
   logic prev_done = 1'b0;

   booth_seq_multiplier #(.WIDTH(W)) dut (
      .clock(clock),
      .clear(clear),
      .start(start),
      .multiplicand(multiplicand),
      .multiplier(multiplier),
      .busy(busy),
      .done(done),
      .hi(hi),
      .lo(lo)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference: plain signed multiplication of the two operands.
   function automatic logic [2*W-1:0] model(input logic [W-1:0] m, input logic [W-1:0] q);
      longint pm;
      longint pq;
      pm = longint'($signed(m));
      pq = longint'($signed(q));
      return 64'(pm * pq);
   endfunction

   // Monitor: every done pulse pops one expected product; done must never last two cycles.
   always @(negedge clock) begin
      if (done) begin
         chk("done_width", 64'(prev_done), 64'(0));
         if (exp_q.size() == 0) chk("unexpected_done", 64'(1), 64'(0));
         else                   chk("product", {hi, lo}, exp_q.pop_front());
      end
      prev_done = done;
   end

   // Issue one op; called at a negedge with the DUT idle, returns at a negedge with the DUT idle.
   // mode 1: re-pulse start with other operands mid-run, change operands, poke start during DONE.
   task automatic run_op(input logic [W-1:0] m, input logic [W-1:0] q, input int mode, input bit push);
      int lat;
      chk("idle_before_start", 64'(busy), 64'(0));
      multiplicand = m;
      multiplier   = q;
      start        = 1'b1;
      if (push) exp_q.push_back(model(m, q));
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      if (mode == 1) begin
         multiplicand = $urandom;
         multiplier   = $urandom;
      end
      lat = 1;
      while (!done && lat < 40) begin
         chk("busy_in_run", 64'(busy), 64'(1));
         if (mode == 1 && lat == 3) begin
            start        = 1'b1;
            multiplicand = 32'd9;
            multiplier   = 32'd9;
         end
         if (mode == 1 && lat == 4) begin
            start        = 1'b0;
            multiplicand = 32'hDEAD_BEEF;
         end
         @(negedge clock);
         lat++;
      end
      chk("done_latency", 64'(lat), 64'(17));
      if (mode == 1) begin
         start        = 1'b1;
         multiplicand = 32'h1111_1111;
         multiplier   = 32'h2222_2222;
      end
      @(negedge clock);
      start = 1'b0;
   endtask

   initial begin
      logic [W-1:0] m;
      logic [W-1:0] q;
      int lat;
      clear = 1'b1;
      start = 1'b0;
      multiplicand = '0;
      multiplier   = '0;
      repeat (3) @(negedge clock);
      chk("reset_busy", 64'(busy), 64'(0));
      chk("reset_done", 64'(done), 64'(0));
      chk("reset_hilo", {hi, lo}, 64'(0));
      clear = 1'b0;
      @(negedge clock);

      // Directed corners.
      run_op(32'd7, 32'hFFFF_FFFD, 0, 1'b1);
      chk("t1_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
      run_op(32'h8000_0000, 32'h8000_0000, 0, 1'b1);
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b1);
      run_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, 1'b1);
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b1);
      run_op(32'h0000_0000, 32'h8000_0000, 0, 1'b1);

      // Start ignored while busy; operand changes after accept have no effect.
      run_op(32'd5, 32'd6, 1, 1'b1);
      chk("t4_hilo", {hi, lo}, 64'h0000_0000_0000_001E);

      // Abort mid-run with clear.
      multiplicand = 32'h1234;
      multiplier   = 32'h5678;
      start        = 1'b1;
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      lat = 1;
      while (lat < 8) begin
         @(negedge clock);
         lat++;
      end
      clear = 1'b1;
      @(negedge clock);
      clear = 1'b0;
      chk("abort_busy", 64'(busy), 64'(0));
      chk("abort_done", 64'(done), 64'(0));
      chk("abort_hilo", {hi, lo}, 64'(0));
      repeat (20) @(negedge clock);
      run_op(32'd3, 32'd4, 0, 1'b1);
      chk("t5_hilo", {hi, lo}, 64'h0000_0000_0000_000C);

      // Random back-to-back ops with occasional corner operands.
      for (int i = 0; i < 2500; i++) begin
         m = $urandom;
         q = $urandom;
         case ($urandom_range(0, 7))
            0: m = 32'h8000_0000;
            1: q = 32'hFFFF_FFFF;
            2: m = 32'h7FFF_FFFF;
            default: ;
         endcase
         run_op(m, q, (i % 16 == 0) ? 1 : 0, 1'b1);
      end

      repeat (3) @(negedge clock);
      chk("queue_drained", 64'(exp_q.size()), 64'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
